// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path (sampler and receive FSM).
package uart_rx_pkg;

  localparam logic [5:0] PRE_4       = 6'd4;
  localparam logic [5:0] PRE_8       = 6'd8;
  localparam logic [5:0] PRE_16      = 6'd16;
  localparam logic [5:0] PRE_32      = 6'd32;
  localparam logic [5:0] PRE_DEFAULT = PRE_8;

  function automatic logic [5:0] legal_pre(input logic [5:0] p);
    case (p)
      PRE_4, PRE_8, PRE_16, PRE_32: return p;
      default:                      return PRE_DEFAULT;
    endcase
  endfunction

  // Centre oversample index of a bit; 2, 4, 8 or 16 for the legal ratios.
  function automatic logic [4:0] mid_idx(input logic [5:0] p);
    return p[5:1];
  endfunction

  function automatic logic [3:0] last_bit(input logic par_en, input int unsigned data_width = 8);
    return 4'(data_width + 1) + 4'(par_en);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser that resets to the idle-high line level; N = 0 is a bypass.
module uart_rx_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  generate
    if (N == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_sync
      logic [N-1:0] sync_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= N'({sync_q, d_i});
      end

      assign q_o = sync_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive oversampling front end: input sync, edge/bit counters and
// 3-sample majority vote around each bit centre.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       PAR_EN,
  input  logic       edge_bit_cnt_en,
  input  logic       dat_samp_en,
  output logic       rx_sync,
  output logic [4:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_valid
);

  logic       en_prev_q;
  logic [5:0] pre_q, pre_d;
  logic [4:0] ecnt_q, ecnt_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic       s0_q, s0_d, s1_q, s1_d;
  logic [1:0] got_q, got_d;
  logic       sb_q, sb_d;
  logic       sv_q, sv_d;

  logic       cnt_start;
  logic [4:0] mid;
  logic [4:0] ecnt_last;
  logic [3:0] last;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_rx_sync #(.N(SYNC_STAGES)) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (RX_IN),
    .q_o   (rx_sync)
  );

  // The ratio is taken straight from the input on the enable rising edge so the
  // very first edge of a frame already uses the new ratio (edge 0 capture at /4).
  assign cnt_start = edge_bit_cnt_en & ~en_prev_q;
  assign pre_d     = cnt_start ? legal_pre(prescale) : pre_q;
  assign mid       = mid_idx(pre_d);
  assign ecnt_last = 5'(pre_d - 6'd1);
  assign last      = last_bit(PAR_EN, DATA_WIDTH);

  always_comb begin
    ecnt_d = '0;
    bcnt_d = '0;
    if (edge_bit_cnt_en) begin
      if (ecnt_q == ecnt_last) begin
        ecnt_d = '0;
        bcnt_d = (bcnt_q >= last) ? 4'd0 : bcnt_q + 4'd1;
      end else begin
        ecnt_d = ecnt_q + 5'd1;
        bcnt_d = bcnt_q;
      end
    end
  end

  // got_q tracks which of the first two votes belong to the current bit, so a
  // vote interrupted by dat_samp_en never completes with stale samples.
  always_comb begin
    s0_d  = s0_q;
    s1_d  = s1_q;
    got_d = got_q;
    sb_d  = sb_q;
    sv_d  = 1'b0;
    if (!dat_samp_en) begin
      got_d = 2'b00;
    end else if (ecnt_q == mid - 5'd2) begin
      s0_d  = rx_sync;
      got_d = 2'b01;
    end else if (ecnt_q == mid - 5'd1) begin
      s1_d  = rx_sync;
      got_d = {got_q[0], got_q[0]};
    end else if (ecnt_q == mid) begin
      got_d = 2'b00;
      if (got_q == 2'b11) begin
        sb_d = maj3(s0_q, s1_q, rx_sync);
        sv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_prev_q <= 1'b0;
      pre_q     <= PRE_DEFAULT;
      ecnt_q    <= '0;
      bcnt_q    <= '0;
      got_q     <= 2'b00;
      sb_q      <= 1'b1;
      sv_q      <= 1'b0;
    end else begin
      en_prev_q <= edge_bit_cnt_en;
      pre_q     <= pre_d;
      ecnt_q    <= ecnt_d;
      bcnt_q    <= bcnt_d;
      got_q     <= got_d;
      sb_q      <= sb_d;
      sv_q      <= sv_d;
    end
  end

  always_ff @(posedge CLK) begin
    s0_q <= s0_d;
    s1_q <= s1_d;
  end

  assign edge_cnt     = ecnt_q;
  assign bit_cnt      = bcnt_q;
  assign sampled_bit  = sb_q;
  assign sample_valid = sv_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed scenarios plus random frames
// compared cycle by cycle against a frame-level arithmetic model.
module tb_uart_rx_sampler;

  localparam int DW  = 8;
  localparam int OFF = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       edge_bit_cnt_en;
  logic       dat_samp_en;
  logic       rx_sync;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int   checks = 0;
  int   errors = 0;
  logic exp_sb;
  logic last_rx1, last_rx2;
  logic line_a [512];
  logic got_bits [$];

  always #5 CLK = ~CLK;

  uart_rx_sampler #(.SYNC_STAGES(2), .DATA_WIDTH(DW)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .RX_IN           (RX_IN),
    .prescale        (prescale),
    .PAR_EN          (PAR_EN),
    .edge_bit_cnt_en (edge_bit_cnt_en),
    .dat_samp_en     (dat_samp_en),
    .rx_sync         (rx_sync),
    .edge_cnt        (edge_cnt),
    .bit_cnt         (bit_cnt),
    .sampled_bit     (sampled_bit),
    .sample_valid    (sample_valid)
  );

  function automatic int model_pre(input int p);
    return (p == 4 || p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  task automatic drive(input logic rx, input logic en, input logic ds);
    RX_IN           = rx;
    edge_bit_cnt_en = en;
    dat_samp_en     = ds;
    last_rx2        = last_rx1;
    last_rx1        = rx;
  endtask

  task automatic test_reset();
    RST = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    checks++; if (edge_cnt !== 5'd0)  begin errors++; $display("FAIL reset_edge got %0d exp 0", edge_cnt); end
    checks++; if (bit_cnt !== 4'd0)   begin errors++; $display("FAIL reset_bit got %0d exp 0", bit_cnt); end
    checks++; if (sampled_bit !== 1'b1) begin errors++; $display("FAIL reset_sb got %b exp 1", sampled_bit); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sv got %b exp 0", sample_valid); end
    checks++; if (rx_sync !== 1'b1)   begin errors++; $display("FAIL reset_rxsync got %b exp 1", rx_sync); end
    RST = 1'b0;
    last_rx1 = 1'b1; last_rx2 = 1'b1; exp_sb = 1'b1;
    @(negedge CLK);
    checks++; if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0) begin
      errors++; $display("FAIL post_reset_cnt got %0d/%0d exp 0/0", edge_cnt, bit_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    PAR_EN = 1'b0; prescale = 6'd8;
    drive(1'b0, 1'b0, 1'b0);
    @(negedge CLK); drive(1'b0, 1'b1, 1'b1);
    repeat (29) @(negedge CLK);
    checks++; if (edge_cnt !== 5'd5 || bit_cnt !== 4'd3) begin
      errors++; $display("FAIL midrst_pre_cnt got %0d/%0d exp 5/3", edge_cnt, bit_cnt);
    end
    checks++; if (sampled_bit !== 1'b0 || sample_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre_sample got %b/%b exp 0/1", sampled_bit, sample_valid);
    end
    #1 RST = 1'b1;
    #1;
    checks++; if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0) begin
      errors++; $display("FAIL midrst_async_cnt got %0d/%0d exp 0/0", edge_cnt, bit_cnt);
    end
    checks++; if (sampled_bit !== 1'b1 || sample_valid !== 1'b0 || rx_sync !== 1'b1) begin
      errors++; $display("FAIL midrst_async_out got sb%b sv%b rx%b exp 1/0/1", sampled_bit, sample_valid, rx_sync);
    end
    @(posedge CLK); #1;
    checks++; if (sampled_bit !== 1'b1 || sample_valid !== 1'b0 || edge_cnt !== 5'd0) begin
      errors++; $display("FAIL midrst_held got sb%b sv%b e%0d exp 1/0/0", sampled_bit, sample_valid, edge_cnt);
    end
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    last_rx1 = 1'b1; last_rx2 = 1'b1; exp_sb = 1'b1;
  endtask

  // One frame: idle cycles with enables low, then enables high from cycle 0.
  // The line is laid out so each frame bit spans pre cycles of rx_sync.
  task automatic run_frame(input int pre_in, input bit par, input logic [7:0] data, input int idle,
                           input int glitch_c, input int glitch_pct, input int chg_c,
                           input int pre_new, input int abort_c);
    int pre, mid, last, n, e, b, base;
    int fb [16];
    logic en, exp_sv;
    logic [4:0] exp_e;
    logic [3:0] exp_b;
    pre  = model_pre(pre_in);
    mid  = pre / 2;
    last = DW + 1 + int'(par);
    n    = (abort_c >= 0) ? abort_c + 3 : (last + 1) * pre + 1;
    for (int i = 0; i < 16; i++) fb[i] = 1;
    fb[0] = 0;
    for (int i = 1; i <= DW; i++) fb[i] = int'(data[i-1]);
    if (par) fb[DW+1] = int'(^data);
    line_a[OFF-idle-2] = last_rx2;
    line_a[OFF-idle-1] = last_rx1;
    for (int c = -idle; c < n; c++) begin
      int k;
      k = c + 2;
      line_a[c+OFF] = (k < 0 || k / pre > last) ? 1'b1 : fb[k/pre][0];
      if (c >= 0 && (c == glitch_c || $urandom_range(99) < glitch_pct)) line_a[c+OFF] = ~line_a[c+OFF];
    end
    PAR_EN = par;
    for (int c = -idle; c < n; c++) begin
      @(negedge CLK);
      exp_e = '0; exp_b = '0; exp_sv = 1'b0;
      if (c >= 0 && (abort_c < 0 || c <= abort_c)) begin
        e = c % pre;
        b = (c / pre) % (last + 1);
        exp_e = 5'(e);
        exp_b = 4'(b);
        exp_sv = (e == mid + 1);
        if (exp_sv) begin
          base = c - e;
          exp_sb = maj3(line_a[base+mid-4+OFF], line_a[base+mid-3+OFF], line_a[base+mid-2+OFF]);
        end
      end
      checks++; if (rx_sync !== line_a[c-2+OFF]) begin
        errors++; $display("FAIL rx_sync c=%0d got %b exp %b", c, rx_sync, line_a[c-2+OFF]);
      end
      checks++; if (sample_valid !== exp_sv) begin
        errors++; $display("FAIL sample_valid c=%0d pre=%0d got %b exp %b", c, pre, sample_valid, exp_sv);
      end
      checks++; if (sampled_bit !== exp_sb) begin
        errors++; $display("FAIL sampled_bit c=%0d pre=%0d got %b exp %b", c, pre, sampled_bit, exp_sb);
      end
      if (c > -idle) begin
        checks++; if (edge_cnt !== exp_e || bit_cnt !== exp_b) begin
          errors++; $display("FAIL counters c=%0d pre=%0d got %0d/%0d exp %0d/%0d", c, pre, edge_cnt, bit_cnt, exp_e, exp_b);
        end
      end
      if (sample_valid) got_bits.push_back(sampled_bit);
      prescale = (chg_c >= 0 && c >= chg_c) ? 6'(pre_new) : 6'(pre_in);
      en = (c >= 0) && (abort_c < 0 || c < abort_c);
      drive(line_a[c+OFF], en, en);
    end
  endtask

  task automatic test_clean_a5();
    int exp_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    got_bits.delete();
    run_frame(8, 1'b0, 8'hA5, 2, -1, 0, -1, 0, -1);
    checks++; if (got_bits.size() != 10) begin
      errors++; $display("FAIL a5_count got %0d exp 10", got_bits.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (got_bits[i] !== exp_seq[i][0]) begin
          errors++; $display("FAIL a5_bit%0d got %b exp %0d", i, got_bits[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    got_bits.delete();
    // Low pulse seen on rx_sync at edge 7 of bit 1 (cycle 23), driven 2 cycles earlier.
    run_frame(16, 1'b0, 8'hFF, 2, 21, 0, -1, 0, -1);
    checks++; if (got_bits.size() < 2 || got_bits[1] !== 1'b1) begin
      errors++; $display("FAIL glitch_vote got %b exp 1", (got_bits.size() < 2) ? 1'bx : got_bits[1]);
    end
  endtask

  task automatic test_prescale_change();
    run_frame(8, 1'b0, 8'h3C, 2, -1, 0, 32, 16, -1);
    run_frame(16, 1'b0, 8'hC3, 1, -1, 0, -1, 0, -1);
  endtask

  task automatic test_parity_32();
    run_frame(32, 1'b1, 8'($urandom), 2, -1, 0, -1, 0, -1);
  endtask

  task automatic test_illegal_and_abort();
    run_frame(5, 1'b0, 8'h5A, 2, -1, 0, -1, 0, -1);
    run_frame(5, 1'b0, 8'h0F, 2, -1, 0, -1, 0, 19);
  endtask

  task automatic test_back_to_back();
    run_frame(4, 1'b0, 8'h96, 1, -1, 0, -1, 0, -1);
    run_frame(4, 1'b1, 8'h61, 1, -1, 0, -1, 0, -1);
  endtask

  task automatic test_random();
    int p, sel;
    for (int i = 0; i < 6; i++) begin
      sel = $urandom_range(4);
      case (sel)
        0: p = 4;
        1: p = 8;
        2: p = 16;
        3: p = 32;
        default: p = $urandom_range(63);
      endcase
      run_frame(p, 1'($urandom), 8'($urandom), $urandom_range(3, 1), -1, 4, -1, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_clean_a5();
    test_glitch();
    test_prescale_change();
    test_parity_32();
    test_illegal_and_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
